// File: rtl/layer_act_loader_pkg.sv
// Shared definitions for the dense-layer activation loader.
// Provides the activation word width, the node fan-in (words per frame),
// the node pipeline latency, the signed activation type and the loader
// state encoding. Optional build macro used by the loader: LOADER_LAST_CHECK_EN.
package layer_pkg;

  localparam int ACT_W    = 16;
  localparam int NUM_IN   = 15;
  localparam int NODE_LAT = 3;
  localparam int IDX_W    = $clog2(NUM_IN);

  typedef logic signed [ACT_W-1:0] act_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } loader_state_t;

endpackage

// File: rtl/layer_act_loader_strobe_delay.sv
// Fixed-depth pulse delay line.
// Ports:
//   clk       in  clock, rising edge
//   reset     in  synchronous, active-high; clears every stage
//   in_pulse  in  strobe to delay
//   out_pulse out in_pulse delayed by exactly DEPTH cycles
// Each stage holds its own bit, so pulses closer together than DEPTH
// cycles are all delivered.
module strobe_delay #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic in_pulse,
  output logic out_pulse
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (reset) sr <= '0;
        else       sr <= in_pulse;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (reset) sr <= '0;
        else       sr <= {sr[DEPTH-2:0], in_pulse};
      end
    end
  endgenerate

  assign out_pulse = sr[DEPTH-1];

endmodule

// File: rtl/layer_act_loader.sv
// Stream-to-parallel activation loader for one dense layer.
// Collects NUM_IN signed words into a shadow bank, then swaps the whole
// frame into the held output bank that drives the node inputs. A strobe
// delay line marks when the node outputs for that frame are valid.
// Build macro: LOADER_LAST_CHECK_EN enables s_last framing checks and the
// sticky frame_err flag; without it s_last is ignored and frame_err is 0.
// Ports:
//   clk, reset    clock / synchronous active-high reset
//   s_valid/s_ready/s_data/s_last  input word stream
//   hold          downstream busy; blocks the bank swap
//   act_out       output bank, word i at [i*ACT_W +: ACT_W]
//   act_update    1-cycle pulse when act_out changed
//   result_valid  act_update delayed by NODE_LAT cycles
//   frame_err     sticky framing error
//
// state | meaning
// FILL  | collecting words into shadow[idx]
// FULL  | shadow holds a complete frame, waiting for hold=0 to swap
import layer_pkg::*;

module layer_act_loader (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [ACT_W-1:0]        s_data,
  input  logic                    s_last,
  input  logic                    hold,
  output logic [NUM_IN*ACT_W-1:0] act_out,
  output logic                    act_update,
  output logic                    result_valid,
  output logic                    frame_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

  loader_state_t    state;
  act_t             shadow [NUM_IN];
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             frame_bad;

  // In FULL the incoming word can only be taken on the swap cycle, since
  // shadow[0] is free once the copy to act_out happens on that same edge.
  assign s_ready = !reset && (state == FILL || !hold);
  assign accept  = s_valid && s_ready;

`ifdef LOADER_LAST_CHECK_EN
  // idx is 0 in FULL, so a word taken on the swap cycle must not carry s_last.
  assign frame_bad = accept && (s_last != (idx == LAST_IDX));
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign frame_bad     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      idx        <= '0;
      act_out    <= '0;
      act_update <= 1'b0;
      frame_err  <= 1'b0;
      for (int i = 0; i < NUM_IN; i++) shadow[i] <= '0;
    end else begin
      act_update <= 1'b0;
      if (frame_bad) frame_err <= 1'b1;
      case (state)
        FILL: begin
          if (accept) begin
            if (frame_bad) begin
              idx <= '0;
            end else begin
              shadow[idx] <= act_t'(s_data);
              if (idx == LAST_IDX) begin
                idx   <= '0;
                state <= FULL;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
        end
        FULL: begin
          if (!hold) begin
            for (int i = 0; i < NUM_IN; i++)
              act_out[i*ACT_W +: ACT_W] <= shadow[i];
            act_update <= 1'b1;
            state      <= FILL;
            if (accept && !frame_bad) begin
              shadow[0] <= act_t'(s_data);
              idx       <= IDX_W'(1);
            end else begin
              idx <= '0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  strobe_delay #(.DEPTH(NODE_LAT)) u_strobe_delay (
    .clk       (clk),
    .reset     (reset),
    .in_pulse  (act_update),
    .out_pulse (result_valid)
  );

endmodule

// File: tb/tb_layer_act_loader.sv
// Scoreboard bench for layer_act_loader. The driver keeps a frame-level
// model (list of accepted words, pending complete frame) and queues the
// expected frame and swap cycle; the monitor pops them when act_update fires
// and tracks the NODE_LAT-delayed result_valid pulses.
module tb_layer_act_loader;
  import layer_pkg::*;

  typedef logic [NUM_IN*ACT_W-1:0] frame_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             s_valid;
  logic             s_ready;
  logic [ACT_W-1:0] s_data;
  logic             s_last;
  logic             hold;
  frame_t           act_out;
  logic             act_update;
  logic             result_valid;
  logic             frame_err;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  frame_t           frame_q[$];
  int               upd_cyc_q[$];
  logic [ACT_W-1:0] words[$];
  bit               full    = 1'b0;
  bit               exp_err = 1'b0;
  frame_t           pend;

  layer_act_loader dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .hold         (hold),
    .act_out      (act_out),
    .act_update   (act_update),
    .result_valid (result_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input frame_t act, input frame_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s @cyc %0d", name, cyc);
  endtask

  // One cycle of stimulus plus the frame-level model update for the coming edge.
  task automatic drive(input bit v, input logic [ACT_W-1:0] d, input bit last, input bit h);
    bit exp_ready;
    bit acc;
    bit bad;
    @(negedge clk);
    s_valid = v; s_data = d; s_last = last; hold = h;
    #1;
    exp_ready = !(full && h);
    check("s_ready", frame_t'(s_ready), frame_t'(exp_ready));
    check("frame_err", frame_t'(frame_err), frame_t'(exp_err));
    acc = v && exp_ready;
    if (full && !h) begin
      frame_q.push_back(pend);
      upd_cyc_q.push_back(cyc + 1);
      full = 1'b0;
    end
    if (acc) begin
      bad = 1'b0;
`ifdef LOADER_LAST_CHECK_EN
      bad = (last != (words.size() == NUM_IN - 1));
`endif
      if (bad) begin
        exp_err = 1'b1;
        words.delete();
      end else begin
        words.push_back(d);
        if (words.size() == NUM_IN) begin
          for (int i = 0; i < NUM_IN; i++) pend[i*ACT_W +: ACT_W] = words[i];
          full = 1'b1;
          words.delete();
        end
      end
    end
  endtask

  // Word with the framing marker the model expects at the current position.
  task automatic send(input bit v, input logic [ACT_W-1:0] d, input bit h);
    drive(v, d, (words.size() == NUM_IN - 1) && !full, h);
  endtask

  task automatic drain();
    repeat (NUM_IN + NODE_LAT + 4) send(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; hold = 1'b0; s_data = '0;
    words.delete(); frame_q.delete(); upd_cyc_q.delete();
    full = 1'b0; exp_err = 1'b0;
    repeat (n) begin
      @(negedge clk); #1;
      check("s_ready_in_reset", frame_t'(s_ready), '0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_s_ready", frame_t'(s_ready), frame_t'(1));
    check("rst_act_out", act_out, '0);
    check("rst_act_update", frame_t'(act_update), '0);
    check("rst_result_valid", frame_t'(result_valid), '0);
    check("rst_frame_err", frame_t'(frame_err), '0);
  endtask

  // Monitor: compares every swap and every result_valid against the queues.
  initial begin
    frame_t exp_act;
    int     rv_q[$];
    int     ec;
    exp_act = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_act = '0;
        rv_q.delete();
      end else begin
        if (act_update) begin
          if (frame_q.size() == 0) begin
            fail_now("act_update_unexpected");
          end else begin
            exp_act = frame_q.pop_front();
            ec = upd_cyc_q.pop_front();
            check("act_update_cycle", frame_t'(cyc), frame_t'(ec));
          end
          rv_q.push_back(cyc + NODE_LAT);
        end else if (upd_cyc_q.size() > 0 && upd_cyc_q[0] < cyc) begin
          fail_now("act_update_missing");
          exp_act = frame_q.pop_front();
          void'(upd_cyc_q.pop_front());
        end
        check("act_out", act_out, exp_act);
        if (result_valid) begin
          if (rv_q.size() == 0) fail_now("result_valid_unexpected");
          else check("result_valid_cycle", frame_t'(cyc), frame_t'(rv_q.pop_front()));
        end else if (rv_q.size() > 0 && rv_q[0] < cyc) begin
          fail_now("result_valid_missing");
          void'(rv_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [ACT_W-1:0] w;
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; hold = 1'b0;
    do_reset(2);

    // Frame 1..15
    for (int i = 0; i < NUM_IN; i++) send(1'b1, ACT_W'(i + 1), 1'b0);
    drain();

    // Negative values at the end slots
    for (int i = 0; i < NUM_IN; i++) begin
      w = ACT_W'($urandom);
      if (i == 0) w = 16'hFFC9;
      if (i == NUM_IN - 1) w = 16'h8000;
      send(1'b1, w, 1'b0);
    end
    drain();

    // Completed frame blocked by hold; word offered during hold lands in slot 0
    for (int i = 0; i < NUM_IN; i++) send(1'b1, ACT_W'($urandom), 1'b0);
    repeat (5) send(1'b1, 16'hA5A5, 1'b1);
    send(1'b1, 16'hA5A5, 1'b0);
    for (int i = 1; i < NUM_IN; i++) send(1'b1, ACT_W'($urandom), 1'b0);
    drain();

    // Two back-to-back frames with continuous s_valid
    for (int i = 0; i < 2 * NUM_IN; i++) send(1'b1, ACT_W'($urandom), 1'b0);
    drain();

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < 7; i++) send(1'b1, ACT_W'($urandom), 1'b0);
    do_reset(1);
    for (int i = 0; i < NUM_IN; i++) send(1'b1, ACT_W'($urandom), 1'b0);
    drain();

`ifdef LOADER_LAST_CHECK_EN
    // Early s_last on word 10 aborts the frame; the next good frame swaps
    for (int i = 0; i < 10; i++) drive(1'b1, ACT_W'($urandom), i == 9, 1'b0);
    for (int i = 0; i < NUM_IN; i++) send(1'b1, ACT_W'($urandom), 1'b0);
    drain();
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bit v, h, last;
      v = ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 3) == 0);
      last = (words.size() == NUM_IN - 1) && !full;
`ifdef LOADER_LAST_CHECK_EN
      if ($urandom_range(0, 31) == 0) last = !last;
`endif
      drive(v, ACT_W'($urandom), last, h);
    end
    drain();

    check("pending_swaps_left", frame_t'(upd_cyc_q.size()), '0);
    do_reset(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
